// File: rtl/rule_conf_cmd_deser.sv
// Deserialises framed 32-bit configuration commands into single-cycle register
// writes for the deparser rule-configuration decoder.
module rule_conf_cmd_deser #(
  parameter logic [7:0]  MAGIC         = 8'hC5,
  parameter int unsigned WR_GAP        = 0,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cfg_valid,
  input  logic [31:0]              i_cfg_data,
  input  logic                     i_cfg_last,
  output logic                     o_cfg_ready,
  output logic                     o_rule_wren,
  output logic [31:0]              o_rule_wdata,
  output logic [31:0]              o_rule_addr,
  output logic                     o_cmd_done,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  localparam logic [3:0] GAP_LOAD = 4'(WR_GAP);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_reg;
  logic [15:0]              base_reg;
  logic [15:0]              offset_reg;
  logic [7:0]               remaining_reg;
  logic [3:0]               gap_reg;
  logic                     wren_reg;
  logic                     done_reg;
  logic [31:0]              wdata_reg;
  logic [15:0]              addr_reg;
  logic [ERR_CNT_WIDTH-1:0] err_reg;

  logic       accept;
  logic       hdr_good;
  logic [7:0] hdr_n;
  logic       err_inc;

  // Ready is forced low while in reset so every output reads 0 during reset.
  assign o_cfg_ready = i_rst_n & (gap_reg == 4'd0);
  assign accept      = i_cfg_valid & o_cfg_ready;
  assign hdr_good    = (i_cfg_data[31:24] == MAGIC);
  assign hdr_n       = i_cfg_data[23:16];

  // Frame-level error detection: at most one event per frame by construction.
  always_comb begin
    err_inc = 1'b0;
    if (accept) begin
      case (state_reg)
        IDLE: begin
          if (!hdr_good)
            err_inc = 1'b1;
          else if (hdr_n == 8'd0)
            err_inc = ~i_cfg_last;
          else
            err_inc = i_cfg_last;
        end
        DATA: begin
          if (remaining_reg == 8'd1)
            err_inc = ~i_cfg_last;
          else
            err_inc = i_cfg_last;
        end
        default: err_inc = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_reg <= '0;
    end else if (err_inc && !(&err_reg)) begin
      err_reg <= err_reg + ERR_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      base_reg      <= 16'h0;
      offset_reg    <= 16'h0;
      remaining_reg <= 8'h0;
      gap_reg       <= 4'h0;
      wren_reg      <= 1'b0;
      done_reg      <= 1'b0;
      wdata_reg     <= 32'h0;
      addr_reg      <= 16'h0;
    end else begin
      wren_reg <= 1'b0;
      done_reg <= 1'b0;
      if (gap_reg != 4'd0)
        gap_reg <= gap_reg - 4'd1;
      if (accept) begin
        case (state_reg)
          IDLE: begin
            if (!hdr_good) begin
              if (!i_cfg_last)
                state_reg <= DROP;
            end else if (hdr_n == 8'd0) begin
              if (i_cfg_last)
                done_reg <= 1'b1;
              else
                state_reg <= DROP;
            end else if (!i_cfg_last) begin
              base_reg      <= i_cfg_data[15:0];
              remaining_reg <= hdr_n;
              offset_reg    <= 16'h0;
              state_reg     <= DATA;
            end
          end
          DATA: begin
            // Address add is 16 bits and wraps around the top of the map.
            wren_reg      <= 1'b1;
            wdata_reg     <= i_cfg_data;
            addr_reg      <= base_reg + offset_reg;
            offset_reg    <= offset_reg + 16'd1;
            remaining_reg <= remaining_reg - 8'd1;
            gap_reg       <= GAP_LOAD;
            if (remaining_reg == 8'd1) begin
              if (i_cfg_last) begin
                done_reg  <= 1'b1;
                state_reg <= IDLE;
              end else begin
                state_reg <= DROP;
              end
            end else if (i_cfg_last) begin
              state_reg <= IDLE;
            end
          end
          DROP: begin
            if (i_cfg_last)
              state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign o_rule_wren  = wren_reg;
  assign o_rule_wdata = wdata_reg;
  assign o_rule_addr  = {16'h0, addr_reg};
  assign o_cmd_done   = done_reg;
  assign o_err_cnt    = err_reg;

endmodule

// File: tb/tb_rule_conf_cmd_deser.sv
// Randomised frame-level bench for rule_conf_cmd_deser: one instance with no
// write gap, one with WR_GAP=2 and a 4-bit error counter, sharing one driver.
module tb_rule_conf_cmd_deser;

  typedef struct {
    int          cyc;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        valid;
  logic [31:0] data;
  logic        last;

  logic        rdy0, rdy1, wren0, wren1, done0, done1;
  logic [31:0] wd0, wd1, ad0, ad1;
  logic [15:0] ec0;
  logic [3:0]  ec1;

  logic        ready, wren, done;
  logic [31:0] wdata, addr;
  logic [15:0] err;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   frame_no = 0;
  int   err_model[2];
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  ev_t  mon_e;
  logic [31:0] fq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rule_conf_cmd_deser #(.MAGIC(8'hC5), .WR_GAP(0), .ERR_CNT_WIDTH(16)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_valid(valid & ~sel), .i_cfg_data(data), .i_cfg_last(last),
    .o_cfg_ready(rdy0), .o_rule_wren(wren0), .o_rule_wdata(wd0),
    .o_rule_addr(ad0), .o_cmd_done(done0), .o_err_cnt(ec0)
  );

  rule_conf_cmd_deser #(.MAGIC(8'hC5), .WR_GAP(2), .ERR_CNT_WIDTH(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_valid(valid & sel), .i_cfg_data(data), .i_cfg_last(last),
    .o_cfg_ready(rdy1), .o_rule_wren(wren1), .o_rule_wdata(wd1),
    .o_rule_addr(ad1), .o_cmd_done(done1), .o_err_cnt(ec1)
  );

  assign ready = sel ? rdy1  : rdy0;
  assign wren  = sel ? wren1 : wren0;
  assign done  = sel ? done1 : done0;
  assign wdata = sel ? wd1   : wd0;
  assign addr  = sel ? ad1   : ad0;
  assign err   = sel ? {12'h0, ec1} : ec0;

  always @(negedge clk) begin
    if (rst_n && (wren || done)) begin
      mon_e.cyc  = cyc;
      mon_e.wren = wren;
      mon_e.addr = addr;
      mon_e.data = wdata;
      mon_e.done = done;
      obs_q.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (frame %0d sel=%0d)", tag, got, expv, frame_no, sel);
    end
  endtask

  task automatic compare_events();
    check("n_events", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("ev_cycle", obs_q[i].cyc, exp_q[i].cyc);
      check("ev_wren", {31'h0, obs_q[i].wren}, {31'h0, exp_q[i].wren});
      if (exp_q[i].wren) begin
        check("ev_addr", obs_q[i].addr, exp_q[i].addr);
        check("ev_data", obs_q[i].data, exp_q[i].data);
      end
      check("ev_done", {31'h0, obs_q[i].done}, {31'h0, exp_q[i].done});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push_ev(input int c, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic dn);
    ev_t e;
    e.cyc = c; e.wren = w; e.addr = a; e.data = d; e.done = dn;
    exp_q.push_back(e);
  endtask

  // Drives one beat; returns the cycle stamp of the negedge at which it was seen ready.
  task automatic send_beat(input logic [31:0] w, input logic l, input bit hold, output int acc);
    int n;
    if (!hold) begin
      valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    valid = 1'b1; data = w; last = l;
    n = 0;
    while (!ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", 32'h0, 32'h1);
      acc = -1;
      valid = 1'b0;
    end else begin
      acc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] w[$], input bit hold);
    int acc[$];
    int a, n, p, m, gap;
    bit good;
    logic [15:0] base;
    for (int i = 0; i < w.size(); i++) begin
      send_beat(w[i], (i == w.size() - 1), hold, a);
      acc.push_back(a);
    end
    valid = 1'b0; last = 1'b0;
    repeat (3) @(negedge clk);
    // Frame-level rules: writes = min(payload, N); success only if payload == N.
    good = (w[0][31:24] == 8'hC5);
    n    = int'(w[0][23:16]);
    p    = w.size() - 1;
    base = w[0][15:0];
    m    = (p < n) ? p : n;
    if (good && n == 0 && p == 0)
      push_ev(acc[0] + 1, 1'b0, 32'h0, 32'h0, 1'b1);
    if (good && n > 0)
      for (int i = 0; i < m; i++)
        push_ev(acc[i + 1] + 1, 1'b1, {16'h0, base + 16'(i)}, w[i + 1],
                (i == n - 1) && (p == n));
    if (!(good && p == n) && err_model[sel] < (sel ? 15 : 65535))
      err_model[sel]++;
    if (hold)
      for (int j = 1; j < w.size(); j++) begin
        gap = (sel && good && n > 0 && j - 1 >= 1 && j - 1 <= m) ? 3 : 1;
        check("accept_spacing", acc[j] - acc[j - 1], gap);
      end
    compare_events();
    check("err_cnt", {16'h0, err}, err_model[sel]);
    $display("frame %0d sel=%0d hdr=%h payload=%0d hold=%0d err=%0d",
             frame_no, sel, w[0], p, hold, err);
    frame_no++;
  endtask

  task automatic rand_frame(input bit hold_en);
    logic [31:0] w[$];
    logic [7:0]  mg;
    logic [15:0] base;
    int n, p;
    mg   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'hC5;
    n    = $urandom_range(0, 5);
    p    = n + $urandom_range(0, 4) - 2;
    if (p < 0) p = 0;
    base = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFFC + 16'($urandom_range(0, 3));
    w.push_back({mg, 8'(n), base});
    for (int i = 0; i < p; i++) w.push_back($urandom);
    send_frame(w, hold_en && ($urandom_range(0, 1) == 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'h0, ready}, 32'h0);
    check({tag, "_wren"},  {31'h0, wren},  32'h0);
    check({tag, "_wdata"}, wdata, 32'h0);
    check({tag, "_addr"},  addr,  32'h0);
    check({tag, "_done"},  {31'h0, done},  32'h0);
    check({tag, "_err"},   {16'h0, err},   32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1;
    rst_n = 1'b0; sel = 1'b0; valid = 1'b0; data = 32'h0; last = 1'b0;
    err_model[0] = 0; err_model[1] = 0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'h0, ready}, 32'h1);
    @(negedge clk);

    // Directed frames on the no-gap instance.
    fq = {32'hC5030100, 32'h1, 32'h2, 32'h3};          send_frame(fq, 1);
    fq = {32'hA0020000, 32'hC5010000, 32'h5};          send_frame(fq, 1);
    fq = {32'hC5010300, 32'hABCD};                     send_frame(fq, 0);
    fq = {32'hC5030400, 32'h10, 32'h11};               send_frame(fq, 1);
    fq = {32'hC5010500, 32'h20, 32'h21, 32'h22};       send_frame(fq, 1);
    fq = {32'hC500ABCD};                               send_frame(fq, 0);
    fq = {32'hC5000000, 32'h7};                        send_frame(fq, 0);
    fq = {32'hC502AAAA};                               send_frame(fq, 0);
    fq = {32'hC503FFFE, 32'h30, 32'h31, 32'h32};       send_frame(fq, 1);
    for (int i = 0; i < 30; i++) rand_frame(1);

    // Reset in the middle of a 3-word frame after one payload beat.
    send_beat(32'hC5030200, 1'b0, 1'b1, a0);
    send_beat(32'h00000011, 1'b0, 1'b1, a1);
    push_ev(a1 + 1, 1'b1, 32'h200, 32'h11, 1'b0);
    #2;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    err_model[0] = 0; err_model[1] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compare_events();
    fq = {32'hC5020210, 32'h22, 32'h23};               send_frame(fq, 1);

    // Gap instance: backpressure spacing, wrap and randomised traffic.
    sel = 1'b1;
    @(negedge clk);
    fq = {32'hC5040600, 32'h40, 32'h41, 32'h42, 32'h43}; send_frame(fq, 1);
    fq = {32'hC503FFFE, 32'h50, 32'h51, 32'h52};         send_frame(fq, 1);
    fq = {32'hC5000000};                                 send_frame(fq, 1);
    for (int i = 0; i < 25; i++) rand_frame(1);

    // Saturation of the 4-bit error counter.
    for (int i = 0; i < 20; i++) begin
      fq = {32'h12000000 | 32'($urandom_range(0, 65535))};
      send_frame(fq, 0);
    end
    check("err_saturated", {16'h0, err}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rule_conf_cmd_deser.md
Name: rule_conf_cmd_deser

Overview:
- Upstream feeder of the deparser rule-configuration decoder.
- Accepts a framed 32-bit configuration command stream (valid/ready/last) from the control-plane path.
- Validates each frame header and serialises the payload into single-cycle 32-bit register writes (wren/wdata/addr).
- Those writes drive the decoder's rule, type, key-offset and shift configuration address map directly.

Parameters:
- MAGIC, 8'hC5: required value of header bits [31:24].
- WR_GAP, 0: idle cycles forced after each emitted write, 0..15; ready is held low during the gap.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  asynchronous active-low reset
- i_cfg_valid  input  1  stream beat valid
- i_cfg_data  input  32  stream beat data
- i_cfg_last  input  1  last beat of frame
- o_cfg_ready  output  1  beat accepted when valid&ready
- o_rule_wren  output  1  one-cycle write strobe
- o_rule_wdata  output  32  write data
- o_rule_addr  output  32  write address; [31:16] always 0
- o_cmd_done  output  1  one-cycle pulse, frame completed without error
- o_err_cnt  output  ERR_CNT_WIDTH  count of bad frames, saturating

Behaviour:
- Reset is asynchronous, active-low, and is the only reset. While i_rst_n=0 every output is 0: ready, wren, wdata, addr, cmd_done, err_cnt. State returns to IDLE and the gap counter clears.
- Beat accepted = i_cfg_valid & o_cfg_ready.
- o_cfg_ready is 1 out of reset exactly when the gap counter is 0, in every state.
- Frame format:
  - Header word: [31:24] magic, [23:16] N = payload word count (0..255), [15:0] base address.
  - Payload: the N following beats.
- FSM states:
  - IDLE:
    - Header accepted with [31:24]!=MAGIC: err_cnt+1. If last=0 go to DROP, else stay IDLE.
    - Good header, N=0, last=1: cmd_done pulse next cycle, stay IDLE.
    - Good header, N=0, last=0: err_cnt+1, go to DROP.
    - Good header, N>0, last=1: err_cnt+1, stay IDLE (truncated frame).
    - Good header, N>0, last=0: latch base, load remaining=N, addr offset=0, go to DATA.
  - DATA, on each accepted beat:
    - Emit a write: o_rule_wren=1 in the cycle after acceptance, o_rule_wdata=beat, o_rule_addr={16'h0, base+offset}. The add is 16-bit and wraps (base 16'hFFFF, offset 1 -> 16'h0000).
    - Increment offset, decrement remaining.
    - remaining becomes 0 with last=1: cmd_done pulse aligned with that final wren; go to IDLE.
    - remaining becomes 0 with last=0: err_cnt+1 (overlong frame), go to DROP. The write is still emitted; cmd_done is not pulsed.
    - remaining>0 with last=1: err_cnt+1 (short frame), go to IDLE. The write is still emitted.
  - DROP: accept and discard beats; the beat with last=1 returns the FSM to IDLE. No writes, no counters change.
- Write latency: exactly 1 cycle from payload acceptance to wren. wren is never high for two consecutive cycles when WR_GAP>0.
- o_rule_wdata and o_rule_addr hold their last written value when wren=0. Only reset clears them.
- Gap: after a payload beat is accepted in DATA, the gap counter loads WR_GAP. Ready is 0 while the counter is non-zero and it decrements each cycle. With WR_GAP=0 there is back-to-back acceptance at 1 beat/cycle.
- err_cnt saturates at all-ones and does not wrap. At most one increment per frame.
- cmd_done and wren are single-cycle pulses, default 0.
- Reset asserted mid-frame aborts the frame: no further writes, IDLE after release. The next beat after release is treated as a header.

Test Plan:
- Good frame, WR_GAP=0: header 32'hC5_03_0100, then 32'h1, 32'h2, 32'h3(last) on consecutive cycles -> wren on 3 consecutive cycles, addr 0x100/0x101/0x102, data 1/2/3; cmd_done coincides with the third wren; err_cnt=0.
- Bad magic: header 32'hA0_02_0000, 2 payload beats, last on the second -> no wren, err_cnt=1. A following good 1-word frame to addr 0x0300 -> one wren at 0x300.
- Short and overlong frames: N=3 frame with last on payload 2 -> 2 writes, err_cnt+1, no cmd_done. N=1 frame with 3 payload beats -> 1 write, err_cnt+1, 2 beats dropped.
- Gap and backpressure: WR_GAP=2, 4-word frame with valid held high -> ready low for 2 cycles after each payload beat, wrens spaced 3 cycles apart, all 4 addresses correct.
- Wrap and edge cases:
  - base 16'hFFFE, N=3 -> addr 0xFFFE, 0xFFFF, 0x0000.
  - Header N=0 with last -> cmd_done and no wren.
  - 2^16+5 bad frames with ERR_CNT_WIDTH=16 -> err_cnt=16'hFFFF.
- Reset mid-frame: assert i_rst_n=0 after 1 of 3 payload beats -> all outputs 0 immediately (asynchronous). After release, a fresh good frame executes normally and the stale remainder produces no write.
